// File: rtl/axi_r_burst_gen_if.sv
// Signal bundle for axi_r_burst_gen: AR request, single-cycle memory port and R beats.
// The slave modport is the generator; the master modport is the requester plus memory.
interface axi_r_burst_gen_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
);
  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [ID_WIDTH-1:0]   ar_id_i;
  logic [ADDR_WIDTH-1:0] ar_addr_i;
  logic [7:0]            ar_len_i;
  logic [2:0]            ar_size_i;
  logic [1:0]            ar_burst_i;
  logic [USER_WIDTH-1:0] ar_user_i;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  r_valid_o;
  logic                  r_ready_i;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic [1:0]            r_resp_o;
  logic [USER_WIDTH-1:0] r_user_o;
  logic [ID_WIDTH-1:0]   r_id_o;
  logic                  r_last_o;

  modport slave (
    input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i,
    output ar_ready_o,
    output mem_req_o, mem_addr_o,
    input  mem_rdata_i,
    output r_valid_o, r_data_o, r_resp_o, r_user_o, r_id_o, r_last_o,
    input  r_ready_i
  );

  modport master (
    output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i,
    input  ar_ready_o,
    input  mem_req_o, mem_addr_o,
    output mem_rdata_i,
    input  r_valid_o, r_data_o, r_resp_o, r_user_o, r_id_o, r_last_o,
    output r_ready_i
  );
endinterface

// File: rtl/axi_r_burst_gen.sv
// AXI read-burst generator: one AR request becomes len+1 memory reads streamed out as R beats.
// Define AXI_R_BURST_GEN_WRAP_EN to accept WRAP bursts; without it WRAP bursts answer SLVERR.
module axi_r_burst_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
) (
  input logic              clk_i,
  input logic              rst_i,
  axi_r_burst_gen_if.slave bus
);
  localparam logic [2:0] MAX_SIZE    = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
`ifdef AXI_R_BURST_GEN_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_next;

  logic                  ar_ready;
  logic                  ar_hs;
  logic                  ar_err;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  r_valid;
  logic                  head_last;
  logic [2:0]            credit;

  logic [ID_WIDTH-1:0]   id_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] step;
  logic [8:0]            issue_cnt_q;
`ifdef AXI_R_BURST_GEN_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask_q;
`endif

  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]            fifo_resp_q [2];
  logic [1:0]            fifo_last_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  assign r_valid   = (count_q != 2'd0);
  assign pop       = r_valid & bus.r_ready_i;
  assign push      = inflight_q;
  assign head_last = fifo_last_q[rd_ptr_q];
  assign ar_hs     = bus.ar_valid_i & ar_ready;
  assign credit    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Illegal sizes and burst types are answered locally with SLVERR beats, no memory reads.
  always_comb begin
    ar_err = (bus.ar_size_i > MAX_SIZE);
    case (bus.ar_burst_i)
      BURST_FIXED, BURST_INCR: begin
      end
`ifdef AXI_R_BURST_GEN_WRAP_EN
      BURST_WRAP: begin
        if (!(bus.ar_len_i inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_err = 1'b1;
      end
`endif
      default: ar_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ar_ready   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        ar_ready = ~rst_i;
        if (bus.ar_valid_i && ar_ready) state_next = BURST;
      end
      BURST: begin
        issue = (issue_cnt_q <= {1'b0, len_q}) && (credit < 3'd2);
        if (pop && head_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    addr_next = addr_q;
    case (burst_q)
      BURST_INCR: addr_next = addr_q + step;
`ifdef AXI_R_BURST_GEN_WRAP_EN
      BURST_WRAP: addr_next = (addr_q & ~wrap_mask_q) | ((addr_q + step) & wrap_mask_q);
`endif
      default:    addr_next = addr_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q            <= '0;
      user_q          <= '0;
      len_q           <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      err_q           <= 1'b0;
      addr_q          <= '0;
      issue_cnt_q     <= '0;
`ifdef AXI_R_BURST_GEN_WRAP_EN
      wrap_mask_q     <= '0;
`endif
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        id_q        <= bus.ar_id_i;
        user_q      <= bus.ar_user_i;
        len_q       <= bus.ar_len_i;
        size_q      <= bus.ar_size_i;
        burst_q     <= bus.ar_burst_i;
        err_q       <= ar_err;
        addr_q      <= bus.ar_addr_i;
        issue_cnt_q <= '0;
`ifdef AXI_R_BURST_GEN_WRAP_EN
        wrap_mask_q <= ((ADDR_WIDTH'(bus.ar_len_i) + ADDR_WIDTH'(1)) << bus.ar_size_i)
                       - ADDR_WIDTH'(1);
`endif
      end else if (issue) begin
        addr_q      <= addr_next;
        issue_cnt_q <= issue_cnt_q + 9'd1;
      end
      // Error beats ride the same one-cycle slot as real reads, so latency is identical.
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_cnt_q[7:0] == len_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_resp_q[0] <= '0;
      fifo_resp_q[1] <= '0;
      fifo_last_q    <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= err_q ? '0 : bus.mem_rdata_i;
        fifo_resp_q[wr_ptr_q] <= err_q ? RESP_SLVERR : RESP_OKAY;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.ar_ready_o = ar_ready;
  assign bus.mem_req_o  = issue & ~err_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.r_valid_o  = r_valid;
  assign bus.r_data_o   = r_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.r_resp_o   = r_valid ? fifo_resp_q[rd_ptr_q] : '0;
  assign bus.r_last_o   = r_valid & head_last;
  assign bus.r_id_o     = r_valid ? id_q : '0;
  assign bus.r_user_o   = r_valid ? user_q : '0;

  // The credit check must keep the FIFO from overflowing, and IDLE implies nothing is pending.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && count_q == 2'd2));
  assert property (@(posedge clk_i) disable iff (rst_i)
                   (state == IDLE) |-> (count_q == 2'd0 && !inflight_q));
endmodule

// File: doc/axi_r_burst_gen.md
AXI_R_BURST_GEN -- requirements
Module: axi_r_burst_gen

Interface
REQ-001 The module SHALL have parameter ID_WIDTH, default 4, the AXI ID width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, the AR/memory address width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 64, the R/memory data width; power of two, at least 8.
REQ-004 The module SHALL have parameter USER_WIDTH, default 6, the user sideband width.
REQ-005 The module SHALL have the following ports: clk_i in 1, the single clock; rst_i in 1, asynchronous active-high reset.
REQ-006 The module SHALL have the AR ports: ar_valid_i in 1; ar_ready_o out 1; ar_id_i in ID_WIDTH; ar_addr_i in ADDR_WIDTH; ar_len_i in 8 (beats-1); ar_size_i in 3; ar_burst_i in 2 (00 FIXED, 01 INCR, 10 WRAP); ar_user_i in USER_WIDTH.
REQ-007 The module SHALL have the memory ports: mem_req_o out 1; mem_addr_o out ADDR_WIDTH; mem_rdata_i in DATA_WIDTH, valid exactly one cycle after mem_req_o.
REQ-008 The module SHALL have the R ports: r_valid_o out 1; r_ready_i in 1; r_data_o out DATA_WIDTH; r_resp_o out 2; r_user_o out USER_WIDTH; r_id_o out ID_WIDTH; r_last_o out 1. They feed the downstream R-channel buffer directly.

Function
REQ-009 The FSM SHALL have two states. IDLE: ar_ready_o=1; an AR handshake latches id/addr/len/size/burst/user and enters BURST. BURST: ar_ready_o=0; it returns to IDLE on the R handshake of the beat with r_last_o=1.
REQ-010 The module SHALL issue one memory read per beat, in address order, exactly len+1 reads per burst.
REQ-011 The address step SHALL be as follows. INCR: add 1<<size. FIXED: hold. WRAP: add 1<<size within the aligned window of (len+1)<<size bytes, and wrap to the window base at the upper boundary.
REQ-012 The module SHALL capture read data into a 2-entry output FIFO, and R fields SHALL be driven from the FIFO head.
REQ-013 Credit rule: mem_req_o SHALL assert only when fifo_count + inflight − (r_valid_o & r_ready_i) < 2, so the FIFO never overflows.
REQ-014 The burst SHALL sustain one beat per cycle while r_ready_i=1.
REQ-015 Latency: with the AR handshake at cycle 0, mem_req_o SHALL be 1 in cycle 1 and r_valid_o SHALL be 1 in cycle 3.
REQ-016 Once r_valid_o=1, r_valid_o and all R fields SHALL stay stable until r_ready_i=1.
REQ-017 r_last_o SHALL be 1 only on beat len+1. r_id_o and r_user_o SHALL equal the latched AR values on every beat.
REQ-018 r_resp_o SHALL be 00 (OKAY) for legal bursts.
REQ-019 A burst with ar_size_i > log2(DATA_WIDTH/8) or ar_burst_i=11 SHALL produce len+1 beats with r_resp_o=10 (SLVERR) and r_data_o=0, and SHALL NOT assert mem_req_o.
REQ-020 A len=0 burst SHALL produce a single beat with r_last_o=1.
REQ-021 An AR handshake SHALL NOT occur in the cycle of the final R handshake; ar_ready_o rises in the following cycle.

Reset
REQ-022 While rst_i=1, all outputs SHALL be 0: ar_ready_o, mem_req_o, mem_addr_o, r_valid_o, r_data_o, r_resp_o, r_user_o, r_id_o, r_last_o. The FSM SHALL be IDLE, and the FIFO and inflight count SHALL be empty.
REQ-023 ar_ready_o SHALL rise in the first cycle after rst_i deasserts.
REQ-024 Reset asserted mid-burst SHALL discard all pending beats and any in-flight read data returned after reset.

Configuration
REQ-025 Macro AXI_R_BURST_GEN_WRAP_EN defined: WRAP bursts SHALL be legal per REQ-011. A WRAP burst with len not in {1,3,7,15} SHALL get SLVERR per REQ-019.
REQ-026 Macro AXI_R_BURST_GEN_WRAP_EN undefined: every WRAP burst SHALL get SLVERR per REQ-019, and the WRAP address logic SHALL be absent.

Verification
REQ-027 INCR: len=3, size=3, addr 0x100, id 0x5, r_ready_i=1 -> mem_addr_o 0x100, 0x108, 0x110, 0x118 on consecutive cycles; 4 OKAY beats; r_id_o=0x5; r_last_o on beat 4 only.
REQ-028 Backpressure: INCR len=7; r_ready_i=0 for 5 cycles after beat 2 -> at most 2 reads outstanding, no beat lost or duplicated, data order preserved.
REQ-029 WRAP (macro defined): len=3, size=3, addr 0x118 -> mem_addr_o 0x118, 0x100, 0x108, 0x110. With the macro undefined -> 4 SLVERR beats with data 0 and no mem_req_o.
REQ-030 FIXED: len=2, addr 0x40 -> three reads at 0x40. Illegal size=4 with DATA_WIDTH=64, len=1 -> 2 SLVERR beats with no mem_req_o.
REQ-031 Reset: rst_i pulsed after beat 2 of len=7 -> all outputs 0 in the same cycle; ar_ready_o=1 one cycle after deassert; no stale beat afterwards.
